// File: rtl/perf_cnt_ctrl.sv
// perf_cnt_ctrl: saturating performance counters gated by software enables and a
// start/stop measurement window, served through a CTRL/LH/UH register window.
module perf_cnt_ctrl #(
    parameter int C_PERF_CNT_WDT = 48,
    parameter int C_PERF_CNT_CNT = 5,
    parameter int C_REG_WDT      = 32,
    parameter int C_ADDR_WDT     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [C_PERF_CNT_CNT-1:0] perf_evt_i,
    input  logic                      perf_start_i,
    input  logic                      perf_stop_i,
    input  logic                      reg_wr_en_i,
    input  logic                      reg_rd_en_i,
    input  logic [C_ADDR_WDT-1:0]     reg_addr_i,
    input  logic [C_REG_WDT-1:0]      reg_wdata_i,
    output logic [C_REG_WDT-1:0]      reg_rdata_o,
    output logic                      reg_rd_valid_o,
    output logic                      reg_err_o,
    output logic [C_PERF_CNT_CNT-1:0] perf_ovf_o
);

    localparam int                        C_HI_WDT  = C_PERF_CNT_WDT - C_REG_WDT;
    localparam logic [C_PERF_CNT_WDT-1:0] C_CNT_MAX = '1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } win_state_e;

    win_state_e state_q, state_d;

    logic [C_PERF_CNT_CNT-1:0] ctrl_hit;
    logic [C_PERF_CNT_CNT-1:0] lh_hit;
    logic [C_PERF_CNT_CNT-1:0] uh_hit;
    logic                      addr_legal;

    logic [C_REG_WDT-1:0] cnt_lo_vec [C_PERF_CNT_CNT];
    logic [C_HI_WDT-1:0]  shadow_vec [C_PERF_CNT_CNT];
    logic [C_REG_WDT-1:0] ctrl_vec   [C_PERF_CNT_CNT];

    logic [C_REG_WDT-1:0] rdata_q, rdata_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 err_q, err_d;

    // Only EN, CLR, AUTO and the OVF clear bit of a CTRL write carry meaning.
    logic unused_wdata;
    assign unused_wdata = ^reg_wdata_i[C_REG_WDT-1:4];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        ctrl_hit = '0;
        lh_hit   = '0;
        uh_hit   = '0;
        for (int i = 0; i < C_PERF_CNT_CNT; i++) begin
            ctrl_hit[i] = (reg_addr_i == C_ADDR_WDT'(3 * i));
            lh_hit[i]   = (reg_addr_i == C_ADDR_WDT'(3 * i + 1));
            uh_hit[i]   = (reg_addr_i == C_ADDR_WDT'(3 * i + 2));
        end
    end

    assign addr_legal = |{ctrl_hit, lh_hit, uh_hit};

    // Stop dominates a simultaneous start; a start while armed is a no-op.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (perf_start_i && !perf_stop_i) state_d = S_ARMED;
            S_ARMED: if (perf_stop_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    for (genvar g = 0; g < C_PERF_CNT_CNT; g++) begin : g_cnt
        logic [C_PERF_CNT_WDT-1:0] cnt_q, cnt_d;
        logic [C_HI_WDT-1:0]       shadow_q, shadow_d;
        logic                      en_q, en_d;
        logic                      auto_q, auto_d;
        logic                      ovf_q, ovf_d;
        logic                      ctrl_wr;
        logic                      inc_req;

        assign ctrl_wr = reg_wr_en_i && ctrl_hit[g];
        assign inc_req = perf_evt_i[g] && en_q && (!auto_q || state_q == S_ARMED);

        always_comb begin
            cnt_d    = cnt_q;
            shadow_d = shadow_q;
            en_d     = en_q;
            auto_d   = auto_q;
            ovf_d    = ovf_q;
            if (ctrl_wr) begin
                en_d   = reg_wdata_i[0];
                auto_d = reg_wdata_i[2];
                if (reg_wdata_i[3]) ovf_d = 1'b0;
            end
            // The upper half is frozen at LH-read time so a following UH read is coherent.
            if (reg_rd_en_i && lh_hit[g]) shadow_d = cnt_q[C_PERF_CNT_WDT-1:C_REG_WDT];
            if (ctrl_wr && reg_wdata_i[1]) begin
                cnt_d    = '0;
                shadow_d = '0;
                ovf_d    = 1'b0;
            end else if (inc_req) begin
                if (cnt_q == C_CNT_MAX) ovf_d = 1'b1;
                else                    cnt_d = cnt_q + C_PERF_CNT_WDT'(1);
            end
        end

        // NOTE: counters and shadows are discrete flops rather than a RAM, so they take the async reset too.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q    <= '0;
                shadow_q <= '0;
                en_q     <= 1'b0;
                auto_q   <= 1'b0;
                ovf_q    <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                shadow_q <= shadow_d;
                en_q     <= en_d;
                auto_q   <= auto_d;
                ovf_q    <= ovf_d;
            end
        end

        assign cnt_lo_vec[g] = cnt_q[C_REG_WDT-1:0];
        assign shadow_vec[g] = shadow_q;
        assign ctrl_vec[g]   = C_REG_WDT'({state_q == S_ARMED, ovf_q, auto_q, 1'b0, en_q});
        assign perf_ovf_o[g] = ovf_q;
    end

    always_comb begin
        rdata_d    = '0;
        rd_valid_d = reg_rd_en_i;
        err_d      = (reg_rd_en_i && !addr_legal) || (reg_wr_en_i && !(|ctrl_hit));
        if (reg_rd_en_i) begin
            for (int i = 0; i < C_PERF_CNT_CNT; i++) begin
                if (ctrl_hit[i]) rdata_d = ctrl_vec[i];
                if (lh_hit[i])   rdata_d = cnt_lo_vec[i];
                if (uh_hit[i])   rdata_d = C_REG_WDT'(shadow_vec[i]);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    assign reg_rdata_o    = rdata_q;
    assign reg_rd_valid_o = rd_valid_q;
    assign reg_err_o      = err_q;

endmodule

// File: tb/tb_perf_cnt_ctrl.sv
// Bench for perf_cnt_ctrl: a word-level model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_perf_cnt_ctrl;

    localparam int NCNT = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  perf_evt = '0;
    logic        perf_start = 1'b0;
    logic        perf_stop = 1'b0;
    logic        reg_wr_en = 1'b0;
    logic        reg_rd_en = 1'b0;
    logic [3:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata;
    logic        reg_rd_valid;
    logic        reg_err;
    logic [4:0]  perf_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    perf_cnt_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .perf_evt_i     (perf_evt),
        .perf_start_i   (perf_start),
        .perf_stop_i    (perf_stop),
        .reg_wr_en_i    (reg_wr_en),
        .reg_rd_en_i    (reg_rd_en),
        .reg_addr_i     (reg_addr),
        .reg_wdata_i    (reg_wdata),
        .reg_rdata_o    (reg_rdata),
        .reg_rd_valid_o (reg_rd_valid),
        .reg_err_o      (reg_err),
        .perf_ovf_o     (perf_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [47:0] m_cnt    [NCNT];
    logic [15:0] m_shadow [NCNT];
    bit          m_en     [NCNT];
    bit          m_auto   [NCNT];
    bit          m_ovf    [NCNT];
    bit          m_armed;
    logic [31:0] exp_rdata = '0;
    bit          exp_valid = 1'b0;
    bit          exp_err = 1'b0;
    int          m_idx;
    int          m_kind;
    bit          m_legal;
    bit          m_inc;
    bit          m_clr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCNT; i++) begin
                m_cnt[i] = '0; m_shadow[i] = '0;
                m_en[i] = 1'b0; m_auto[i] = 1'b0; m_ovf[i] = 1'b0;
            end
            m_armed = 1'b0;
            exp_rdata = '0; exp_valid = 1'b0; exp_err = 1'b0;
        end else begin
            m_idx   = int'(reg_addr) / 3;
            m_kind  = int'(reg_addr) % 3;
            m_legal = int'(reg_addr) < 3 * NCNT;
            exp_valid = reg_rd_en;
            exp_rdata = '0;
            exp_err = (reg_rd_en && !m_legal) || (reg_wr_en && !(m_legal && m_kind == 0));
            if (reg_rd_en && m_legal) begin
                case (m_kind)
                    0: exp_rdata = {27'd0, m_armed, m_ovf[m_idx], m_auto[m_idx], 1'b0, m_en[m_idx]};
                    1: exp_rdata = m_cnt[m_idx][31:0];
                    default: exp_rdata = {16'd0, m_shadow[m_idx]};
                endcase
                if (m_kind == 1) m_shadow[m_idx] = m_cnt[m_idx][47:32];
            end
            for (int i = 0; i < NCNT; i++) begin
                m_inc = perf_evt[i] && m_en[i] && (!m_auto[i] || m_armed);
                m_clr = reg_wr_en && m_legal && m_kind == 0 && m_idx == i && reg_wdata[1];
                if (reg_wr_en && m_legal && m_kind == 0 && m_idx == i && reg_wdata[3]) m_ovf[i] = 1'b0;
                if (m_clr) begin
                    m_cnt[i] = '0; m_shadow[i] = '0; m_ovf[i] = 1'b0;
                end else if (m_inc) begin
                    if (m_cnt[i] == 48'hFFFF_FFFF_FFFF) m_ovf[i] = 1'b1;
                    else m_cnt[i] = m_cnt[i] + 48'd1;
                end
            end
            if (reg_wr_en && m_legal && m_kind == 0) begin
                m_en[m_idx]   = reg_wdata[0];
                m_auto[m_idx] = reg_wdata[2];
            end
            if (perf_stop)       m_armed = 1'b0;
            else if (perf_start) m_armed = 1'b1;
        end
    end

    logic [4:0] exp_ovf_vec;
    always_comb begin
        exp_ovf_vec = '0;
        for (int i = 0; i < NCNT; i++) exp_ovf_vec[i] = m_ovf[i];
    end

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        check("model_rd_valid", {63'd0, reg_rd_valid}, {63'd0, exp_valid});
        if (exp_valid) check("model_rdata", {32'd0, reg_rdata}, {32'd0, exp_rdata});
        check("model_err", {63'd0, reg_err}, {63'd0, exp_err});
        check("model_ovf", {59'd0, perf_ovf}, {59'd0, exp_ovf_vec});
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic reg_write(input logic [3:0] addr, input logic [31:0] data);
        reg_wr_en = 1'b1; reg_addr = addr; reg_wdata = data;
        @(negedge clk);
        reg_wr_en = 1'b0; reg_wdata = '0;
    endtask

    task automatic reg_read(input logic [3:0] addr, output logic [31:0] data);
        reg_rd_en = 1'b1; reg_addr = addr;
        @(negedge clk);
        reg_rd_en = 1'b0;
        data = reg_rdata;
    endtask

    task automatic read_check(input string name, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        reg_read(addr, d);
        check(name, {32'd0, d}, {32'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rdata", {32'd0, reg_rdata}, 64'd0);
        check("reset_valid", {63'd0, reg_rd_valid}, 64'd0);
        check("reset_ovf", {59'd0, perf_ovf}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        read_check("reset_ctrl0", 4'd0, 32'h0);

        // Plain counting on counter 1
        reg_write(4'd3, 32'h1);
        perf_evt = 5'b00010;
        repeat (10) @(negedge clk);
        perf_evt = '0;
        reg_read(4'd4, d);
        check("c1_lh", {32'd0, d}, 64'd10);
        check("c1_valid_hi", {63'd0, reg_rd_valid}, 64'd1);
        @(negedge clk);
        check("c1_valid_lo", {63'd0, reg_rd_valid}, 64'd0);
        read_check("c1_uh", 4'd5, 32'h0);

        // AUTO counter 0 over a 20-cycle window
        reg_write(4'd0, 32'h5);
        perf_evt = 5'b00001;
        repeat (3) @(negedge clk);
        perf_start = 1'b1;
        @(negedge clk);
        perf_start = 1'b0;
        for (int i = 0; i < 19; i++) begin
            reg_rd_en = (i == 5);
            reg_addr = 4'd0;
            @(negedge clk);
            if (i == 5) check("c0_ctrl_armed", {32'd0, reg_rdata}, 64'h15);
        end
        reg_rd_en = 1'b0;
        perf_stop = 1'b1;
        @(negedge clk);
        perf_stop = 1'b0;
        repeat (3) @(negedge clk);
        perf_evt = '0;
        read_check("c0_ctrl_idle", 4'd0, 32'h5);
        read_check("c0_lh_window", 4'd1, 32'd20);

        // Saturation on counter 4
        reg_write(4'd12, 32'h1);
        force dut.g_cnt[4].cnt_d = 48'hFFFF_FFFF_FFFE;
        m_cnt[4] = 48'hFFFF_FFFF_FFFE;
        @(negedge clk);
        release dut.g_cnt[4].cnt_d;
        perf_evt = 5'b10000;
        repeat (3) @(negedge clk);
        perf_evt = '0;
        check("c4_ovf_out", {59'd0, perf_ovf}, 64'h10);
        read_check("c4_lh_max", 4'd13, 32'hFFFF_FFFF);
        read_check("c4_uh_max", 4'd14, 32'h0000_FFFF);
        read_check("c4_ctrl_ovf", 4'd12, 32'h9);
        reg_write(4'd12, 32'h9);
        check("c4_ovf_cleared", {59'd0, perf_ovf}, 64'h0);
        read_check("c4_ctrl_after", 4'd12, 32'h1);

        // Coherent LH/UH across an upper-half carry on counter 3
        reg_write(4'd9, 32'h1);
        force dut.g_cnt[3].cnt_d = 48'h0000_FFFF_FFFF;
        m_cnt[3] = 48'h0000_FFFF_FFFF;
        @(negedge clk);
        release dut.g_cnt[3].cnt_d;
        perf_evt = 5'b01000;
        reg_read(4'd10, d);
        perf_evt = '0;
        check("c3_lh_pre", {32'd0, d}, 64'hFFFF_FFFF);
        read_check("c3_uh_coherent", 4'd11, 32'h0);
        read_check("c3_lh_post", 4'd10, 32'h0);
        read_check("c3_uh_post", 4'd11, 32'h1);

        // CLR against a same-cycle event, and start+stop together
        perf_evt = 5'b00010;
        reg_write(4'd3, 32'h3);
        perf_evt = '0;
        read_check("c1_clr", 4'd4, 32'h0);
        perf_start = 1'b1; perf_stop = 1'b1;
        @(negedge clk);
        perf_start = 1'b0; perf_stop = 1'b0;
        perf_evt = 5'b00001;
        repeat (2) @(negedge clk);
        perf_evt = '0;
        read_check("startstop_idle", 4'd0, 32'h5);

        // Illegal accesses
        reg_write(4'd2, 32'hDEAD_BEEF);
        check("err_wr_uh", {63'd0, reg_err}, 64'd1);
        @(negedge clk);
        check("err_clears", {63'd0, reg_err}, 64'd0);
        reg_write(4'd1, 32'h1234_5678);
        check("err_wr_lh", {63'd0, reg_err}, 64'd1);
        reg_read(4'd15, d);
        check("bad_rd_data", {32'd0, d}, 64'd0);
        check("bad_rd_valid", {63'd0, reg_rd_valid}, 64'd1);
        check("bad_rd_err", {63'd0, reg_err}, 64'd1);
        read_check("c0_unchanged", 4'd1, 32'd20);

        // Reset while armed with a read in flight
        perf_evt = 5'b10000;
        @(negedge clk);
        perf_evt = '0;
        check("c4_ovf_again", {59'd0, perf_ovf}, 64'h10);
        perf_start = 1'b1;
        @(negedge clk);
        perf_start = 1'b0;
        reg_rd_en = 1'b1; reg_addr = 4'd4;
        @(posedge clk);
        #1 rst_n = 1'b0;
        reg_rd_en = 1'b0;
        @(negedge clk);
        check("rst_valid", {63'd0, reg_rd_valid}, 64'd0);
        check("rst_rdata", {32'd0, reg_rdata}, 64'd0);
        check("rst_ovf", {59'd0, perf_ovf}, 64'd0);
        check("rst_err", {63'd0, reg_err}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_check("rst_ctrl0", 4'd0, 32'h0);
        read_check("rst_lh0", 4'd1, 32'h0);
        read_check("rst_lh4", 4'd13, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
